vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing on the 25 MHz pixel clock produced by the clock divider. The divider sits directly upstream of this block.
- Outputs:
  - pixel coordinates
  - hsync/vsync
  - a visible-area flag
  - line-end and frame-end strobes
  - a frame-rate blink signal for the Sudoku cursor
- Consumers are the board/cursor renderer and the VGA output pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse (0 = active-low)
- BLINK_FRAMES, 30, frames per blink half-period (range 1..255)

Ports:
- clk25  input  1  25 MHz pixel clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- hcount  output  10  current pixel column, 0..H_TOTAL-1
- vcount  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high when hcount<H_VISIBLE and vcount<V_VISIBLE
- line_end  output  1  one-cycle strobe at hcount==H_TOTAL-1
- frame_end  output  1  one-cycle strobe at hcount==H_TOTAL-1 and vcount==V_TOTAL-1
- blink  output  1  toggles every BLINK_FRAMES frames

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525
- All outputs are registered; no combinational path from counters to ports. Every output describes the position currently shown on hcount/vcount in the same cycle: zero relative latency, with decode computed from next-state counts.
- Reset: rst high at a clk25 edge loads position (0,0):
  - hcount=0, vcount=0
  - video_on=1
  - hsync=vsync=~SYNC_ACTIVE
  - line_end=0, frame_end=0
  - blink=0, internal frame counter=0
  - Reset mid-frame aborts the frame immediately; no strobe is emitted for the aborted frame.
- Horizontal counter:
  - Increments every cycle.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Increments only on the horizontal wrap edge.
  - At V_TOTAL-1 together with hcount==H_TOTAL-1, both counters wrap to 0 on the same edge.
- hsync = SYNC_ACTIVE iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751 inclusive.
- vsync = SYNC_ACTIVE iff V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC, i.e. lines 490..491 inclusive, for all 800 pixels of those lines.
- video_on is 0 throughout porches and sync regions.
- line_end:
  - High exactly one cycle per line, at hcount==799, on every line including blanking lines.
  - frame_end coincides with line_end on line 524.
- Blink:
  - An 8-bit frame counter increments on the edge where frame_end is high.
  - When the counter equals BLINK_FRAMES-1 at that edge, it wraps to 0 and blink toggles on the same edge. Blink therefore changes exactly when position returns to (0,0).
  - BLINK_FRAMES=1 toggles blink every frame.
- No stall or enable input: the raster runs continuously out of reset.
- Parameter sanity: all porch/sync parameters must be >=1, and H_TOTAL, V_TOTAL must be <=1024. Elaboration-time assertion on violation.

Test Plan:
- Reset: hold rst 3 cycles, then release.
  - During reset: hcount=0, vcount=0, video_on=1, hsync=vsync=1, strobes 0, blink=0.
  - First edge after release: hcount=1.
- Horizontal timing from reset:
  - video_on falls at hcount=640.
  - hsync low for hcount 656..751 (96 cycles), high at 752.
  - line_end high only at hcount=799.
  - Next cycle: hcount=0, vcount=1.
- Vertical timing:
  - vsync low from (0,490) through (799,491), 1600 cycles.
  - video_on stays 0 for vcount 480..524.
- Frame wrap:
  - At (799,524): line_end=1 and frame_end=1.
  - Next cycle: (0,0), video_on=1.
  - Frame period is exactly 420000 cycles.
- Blink with BLINK_FRAMES=2:
  - blink goes 0→1 at start of frame 2 and 1→0 at start of frame 4.
  - No toggle at any other cycle.
- Mid-frame reset:
  - Assert rst at (300,200) for 1 cycle → next cycle (0,0) with blink=0.
  - frame_end is not asserted for the aborted frame.
  - Timing from (0,0) matches the horizontal timing scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing on the 25 MHz pixel clock.
// Ports: clk25/rst in; hcount, vcount, hsync, vsync, video_on,
//   line_end, frame_end, blink out (all registered).
module vga_timing_gen #(
  parameter int   H_VISIBLE    = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_VISIBLE    = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter logic SYNC_ACTIVE  = 1'b0,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic       clk25,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_end,
  output logic       blink
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_END  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [7:0] BF_END = 8'(BLINK_FRAMES - 1);

  if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > 1024 || V_TOTAL > 1024 ||
      BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_param_err
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_end_q, line_end_d;
  logic       frame_end_q, frame_end_d;
  logic       blink_q, blink_d;
  logic [7:0] fcnt_q, fcnt_d;

  logic h_wrap;
  logic v_wrap;

  always_comb begin
    h_wrap = (hcount_q == H_END);
    v_wrap = (vcount_q == V_END);

    hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
    end

    // frame_end_q marks the last pixel of the frame, so the
    // counter steps on the same edge that returns to (0,0).
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_end_q) begin
      if (fcnt_q == BF_END) begin
        fcnt_d  = 8'd0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end

    if (rst) begin
      hcount_d = 10'd0;
      vcount_d = 10'd0;
      fcnt_d   = 8'd0;
      blink_d  = 1'b0;
    end

    // Decode from the next position so every registered output
    // lines up with the registered counters.
    video_on_d  = (hcount_d < H_VIS) && (vcount_d < V_VIS);
    hsync_d     = ((hcount_d >= HS_BEG) && (hcount_d < HS_END)) ?
                  SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d     = ((vcount_d >= VS_BEG) && (vcount_d < VS_END)) ?
                  SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_end_d  = (hcount_d == H_END);
    frame_end_d = (hcount_d == H_END) && (vcount_d == V_END);
  end

  always_ff @(posedge clk25) begin
    hcount_q    <= hcount_d;
    vcount_q    <= vcount_d;
    hsync_q     <= hsync_d;
    vsync_q     <= vsync_d;
    video_on_q  <= video_on_d;
    line_end_q  <= line_end_d;
    frame_end_q <= frame_end_d;
    blink_q     <= blink_d;
    fcnt_q      <= fcnt_d;
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen on a
// shrunken raster (25x15 totals) so full frames stay short.
module tb_vga_timing_gen;

  localparam int HV = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VV = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int BF = 2;
  localparam int HT = 25;
  localparam int VT = 15;
  localparam int FRAME = 375;

  logic       clk25;
  logic       rst;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_end;
  logic       frame_end;
  logic       blink;

  int errors;
  int checks;

  int   eh;
  int   ev;
  int   fc;
  logic eb;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .BLINK_FRAMES(BF)
  ) dut (
    .clk25(clk25),
    .rst(rst),
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .line_end(line_end),
    .frame_end(frame_end),
    .blink(blink)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  task automatic tick();
    @(posedge clk25);
    #1;
    if (rst) begin
      eh = 0; ev = 0; fc = 0; eb = 1'b0;
    end else begin
      if (eh == HT-1 && ev == VT-1) begin
        if (fc == BF-1) begin
          fc = 0;
          eb = ~eb;
        end else begin
          fc++;
        end
      end
      if (eh == HT-1) begin
        eh = 0;
        ev = (ev == VT-1) ? 0 : ev + 1;
      end else begin
        eh++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hcount !== 10'd0 || vcount !== 10'd0) begin
        errors++;
        $display("FAIL reset_pos: got (%0d,%0d) want (0,0)",
                 hcount, vcount);
      end
      checks++;
      if ({video_on, hsync, vsync, line_end, frame_end, blink}
          !== 6'b111000) begin
        errors++;
        $display("FAIL reset_flags: got %b want 111000",
                 {video_on, hsync, vsync,
                  line_end, frame_end, blink});
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (hcount !== 10'd1 || vcount !== 10'd0) begin
      errors++;
      $display("FAIL reset_release: got (%0d,%0d) want (1,0)",
               hcount, vcount);
    end
  endtask

  task automatic test_horizontal(input string tag);
    int bad, hs_low, le_cnt, first_off;
    bad = 0; hs_low = 0; le_cnt = 0; first_off = -1;
    while (eh != 0) begin
      if (!video_on && first_off < 0) first_off = eh;
      if (!hsync) hs_low++;
      if (line_end) le_cnt++;
      if (hcount !== 10'(eh) ||
          video_on !== (eh < HV) ||
          hsync !== !(eh >= 18 && eh < 22) ||
          line_end !== (eh == 24) ||
          frame_end !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_sweep: %0d bad cycles want 0", tag, bad);
    end
    checks++;
    if (first_off !== 16) begin
      errors++;
      $display("FAIL %s_video_fall: at %0d want 16",
               tag, first_off);
    end
    checks++;
    if (hs_low !== 4) begin
      errors++;
      $display("FAIL %s_hsync_width: got %0d want 4", tag, hs_low);
    end
    checks++;
    if (le_cnt !== 1) begin
      errors++;
      $display("FAIL %s_line_end_cnt: got %0d want 1", tag, le_cnt);
    end
    checks++;
    if (hcount !== 10'd0 || vcount !== 10'd1) begin
      errors++;
      $display("FAIL %s_next_line: got (%0d,%0d) want (0,1)",
               tag, hcount, vcount);
    end
  endtask

  task automatic test_vertical();
    int bad, vs_low, vid_blank, n;
    bad = 0; vs_low = 0; vid_blank = 0; n = 0;
    while (frame_end !== 1'b1 && n < 2*FRAME) begin
      if (!vsync) vs_low++;
      if (video_on && vcount >= 10'd8) vid_blank++;
      if (vsync !== !(ev >= 10 && ev < 12) ||
          video_on !== (eh < HV && ev < VV) ||
          line_end !== (eh == HT-1)) bad++;
      tick();
      n++;
    end
    checks++;
    if (n >= 2*FRAME) begin
      errors++;
      $display("FAIL vert_timeout: no frame_end in %0d cycles", n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL vert_sweep: %0d bad cycles want 0", bad);
    end
    checks++;
    if (vs_low !== 50) begin
      errors++;
      $display("FAIL vsync_width: got %0d want 50", vs_low);
    end
    checks++;
    if (vid_blank !== 0) begin
      errors++;
      $display("FAIL video_blank: got %0d want 0", vid_blank);
    end
    checks++;
    if (hcount !== 10'd24 || vcount !== 10'd14 || !line_end) begin
      errors++;
      $display("FAIL frame_end_pos: got (%0d,%0d) le=%b want (24,14) le=1",
               hcount, vcount, line_end);
    end
  endtask

  task automatic test_frame_wrap();
    int n;
    tick();
    checks++;
    if (hcount !== 10'd0 || vcount !== 10'd0 || !video_on ||
        frame_end || line_end) begin
      errors++;
      $display("FAIL wrap_origin: got (%0d,%0d) vid=%b fe=%b le=%b want (0,0) 1 0 0",
               hcount, vcount, video_on, frame_end, line_end);
    end
    n = 1;
    while (frame_end !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== FRAME) begin
      errors++;
      $display("FAIL frame_period: got %0d want %0d", n, FRAME);
    end
  endtask

  task automatic test_blink();
    int bad, tog, t1, t2, badpos;
    logic pb;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 0; tog = 0; t1 = -1; t2 = -1; badpos = 0;
    pb = blink;
    for (int i = 1; i <= 5*FRAME; i++) begin
      tick();
      if (blink !== eb) bad++;
      if (blink !== pb) begin
        tog++;
        if (tog == 1) t1 = i;
        if (tog == 2) t2 = i;
        if (hcount !== 10'd0 || vcount !== 10'd0) badpos++;
      end
      pb = blink;
    end
    checks++;
    if (tog !== 2) begin
      errors++;
      $display("FAIL blink_toggles: got %0d want 2", tog);
    end
    checks++;
    if (t1 !== 750) begin
      errors++;
      $display("FAIL blink_rise: at %0d want 750", t1);
    end
    checks++;
    if (t2 !== 1500) begin
      errors++;
      $display("FAIL blink_fall: at %0d want 1500", t2);
    end
    checks++;
    if (badpos !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL blink_track: badpos=%0d bad=%0d want 0 0",
               badpos, bad);
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    n = 0;
    while (!(eb && eh == 12 && ev == 5) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000 || blink !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: n=%0d blink=%b want blink 1", n, blink);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (hcount !== 10'd0 || vcount !== 10'd0 || blink !== 1'b0 ||
        frame_end || line_end || !video_on) begin
      errors++;
      $display("FAIL mid_reset: got (%0d,%0d) bl=%b fe=%b le=%b vid=%b",
               hcount, vcount, blink, frame_end, line_end, video_on);
    end
    tick();
    test_horizontal("mid");
    n = HT;
    while (frame_end !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== FRAME-1) begin
      errors++;
      $display("FAIL mid_first_frame_end: at %0d want %0d",
               n, FRAME-1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    eh = 0; ev = 0; fc = 0; eb = 1'b0;
    test_reset();
    test_horizontal("horiz");
    test_vertical();
    test_frame_wrap();
    test_blink();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
